packet_link_arbiter: RTL and testbench

PACKET_LINK_ARBITER -- requirements
Module: packet_link_arbiter

---
 rtl/packet_link_arbiter.sv | 171 +++++++++++++++++
 tb/tb_packet_link_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_link_arbiter.sv
// Round-robin arbiter that hands a single 13-bit flit link to one of four
// packet sources at a time, holding ownership until end-of-packet or a flit cap.
module packet_link_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAXFLITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      in_valid,
  input  logic [13*NREQ-1:0]   in_packet,
  output logic [NREQ-1:0]      in_ready,
  output logic                 out_valid,
  output logic [12:0]          out_packet,
  input  logic                 out_ready,
  output logic [NREQ-1:0]      grant,
  output logic                 complete,
  output logic                 overflow,
  output logic [4:0]           flit_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] MAX_CNT = 5'(MAXFLITS);

  state_t      state_r, state_s;
  logic [3:0]  grant_r, grant_s;
  logic [1:0]  owner_r, owner_s;
  logic [1:0]  rr_ptr_r, rr_ptr_s;
  logic [4:0]  cnt_r, cnt_s;
  logic        complete_r, complete_s;
  logic        overflow_r, overflow_s;

  logic [7:0]  dbl_s;
  logic [3:0]  rot_s;
  logic [1:0]  win_off_s, win_idx_s;
  logic [12:0] flit_s;
  logic        owner_valid_s, hs_s;
  logic [4:0]  cnt_inc_s;

  // Round-robin pick: rotate requests so rr_ptr lands at bit 0, take lowest set bit
  always_comb begin
    dbl_s = {in_valid, in_valid};
    rot_s = 4'(dbl_s >> rr_ptr_r);
    casez (rot_s)
      4'b???1: win_off_s = 2'd0;
      4'b??10: win_off_s = 2'd1;
      4'b?100: win_off_s = 2'd2;
      4'b1000: win_off_s = 2'd3;
      default: win_off_s = 2'd0;
    endcase
    win_idx_s = rr_ptr_r + win_off_s;
  end

  // Owner flit mux, handshake detect and saturating flit increment
  always_comb begin
    case (owner_r)
      2'd0:    flit_s = in_packet[12:0];
      2'd1:    flit_s = in_packet[25:13];
      2'd2:    flit_s = in_packet[38:26];
      2'd3:    flit_s = in_packet[51:39];
      default: flit_s = 13'd0;
    endcase
    owner_valid_s = in_valid[owner_r];
    hs_s          = (state_r == XFER) & owner_valid_s & out_ready;
    cnt_inc_s     = (cnt_r == 5'd31) ? 5'd31 : cnt_r + 5'd1;
  end

  // Link-side outputs pass through combinationally only while a packet is moving
  always_comb begin
    out_valid  = 1'b0;
    out_packet = 13'd0;
    in_ready   = 4'b0000;
    if (state_r == XFER) begin
      out_valid  = owner_valid_s;
      out_packet = flit_s;
      in_ready   = grant_r & {4{out_ready}};
    end else begin
      out_valid  = 1'b0;
      out_packet = 13'd0;
      in_ready   = 4'b0000;
    end
  end

  // Next-state and next-register values
  always_comb begin
    state_s    = state_r;
    grant_s    = grant_r;
    owner_s    = owner_r;
    rr_ptr_s   = rr_ptr_r;
    cnt_s      = cnt_r;
    complete_s = 1'b0;
    overflow_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (|in_valid) begin
          state_s = XFER;
          grant_s = 4'b0001 << win_idx_s;
          owner_s = win_idx_s;
          cnt_s   = 5'd0;
        end else begin
          grant_s = 4'b0000;
        end
      end
      XFER: begin
        if (hs_s) begin
          cnt_s = cnt_inc_s;
          if (flit_s[12]) begin
            state_s    = DONE;
            complete_s = 1'b1;
          end else if (cnt_inc_s == MAX_CNT) begin
            // Cap reached without eop: cut the packet short and flag it
            state_s    = DONE;
            complete_s = 1'b1;
            overflow_s = 1'b1;
          end else begin
            state_s = XFER;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      DONE: begin
        state_s  = IDLE;
        grant_s  = 4'b0000;
        rr_ptr_s = owner_r + 2'd1;
      end
      default: begin
        state_s = IDLE;
        grant_s = 4'b0000;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Ownership, pointer, count and pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_r    <= 4'b0000;
      owner_r    <= 2'd0;
      rr_ptr_r   <= 2'd0;
      cnt_r      <= 5'd0;
      complete_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      grant_r    <= grant_s;
      owner_r    <= owner_s;
      rr_ptr_r   <= rr_ptr_s;
      cnt_r      <= cnt_s;
      complete_r <= complete_s;
      overflow_r <= overflow_s;
    end
  end

  assign grant      = grant_r;
  assign complete   = complete_r;
  assign overflow   = overflow_r;
  assign flit_count = cnt_r;

endmodule

// File: tb/tb_packet_link_arbiter.sv
// Self-checking bench for packet_link_arbiter: directed scenarios plus a
// randomized run checked against a packet-level reference model.
module tb_packet_link_arbiter;

  logic        clk, rst;
  logic [3:0]  in_valid;
  logic [51:0] in_packet;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [12:0] out_packet;
  logic        out_ready;
  logic [3:0]  grant;
  logic        complete, overflow;
  logic [4:0]  flit_count;

  int errors = 0;
  int checks = 0;

  logic [12:0] fq [4][$];

  packet_link_arbiter #(.NREQ(4), .MAXFLITS(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_packet(in_packet),
    .in_ready(in_ready), .out_valid(out_valid), .out_packet(out_packet),
    .out_ready(out_ready), .grant(grant), .complete(complete),
    .overflow(overflow), .flit_count(flit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit exceeded");
    $fatal(1, "watchdog");
  end

  task automatic set_flit(input int r, input logic [12:0] f);
    in_packet[13*r +: 13] = f;
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 4'b0000; in_packet = 52'd0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'b1111; in_packet = {52{1'b1}}; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant got=%b exp=0000", grant); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL rst_in_ready got=%b exp=0000", in_ready); end
    checks++; if (out_packet !== 13'd0) begin errors++; $display("FAIL rst_out_packet got=%h exp=0", out_packet); end
    checks++; if ({complete, overflow} !== 2'b00) begin errors++; $display("FAIL rst_pulses got=%b exp=00", {complete, overflow}); end
    checks++; if (flit_count !== 5'd0) begin errors++; $display("FAIL rst_flit_count got=%0d exp=0", flit_count); end
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_single_packet();
    do_reset();
    in_valid = 4'b0001; set_flit(0, 13'h0123); out_ready = 1'b1;
    #1;
    checks++; if ({grant, out_valid} !== 5'b0000_0) begin errors++; $display("FAIL single_idle got=%b exp=00000", {grant, out_valid}); end
    @(negedge clk); #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant got=%b exp=0001", grant); end
    checks++; if ({out_valid, out_packet, in_ready, flit_count} !== {1'b1, 13'h0123, 4'b0001, 5'd0})
      begin errors++; $display("FAIL single_flit0 got=%b/%h/%b/%0d exp=1/0123/0001/0", out_valid, out_packet, in_ready, flit_count); end
    @(negedge clk);
    set_flit(0, 13'h1456); #1;
    checks++; if ({out_valid, out_packet} !== {1'b1, 13'h1456}) begin errors++; $display("FAIL single_flit1 got=%b/%h exp=1/1456", out_valid, out_packet); end
    @(negedge clk);
    in_valid = 4'b0000; #1;
    checks++; if ({complete, overflow, grant, out_valid, flit_count} !== {1'b1, 1'b0, 4'b0001, 1'b0, 5'd2})
      begin errors++; $display("FAIL single_done got=%b%b/%b/%b/%0d exp=10/0001/0/2", complete, overflow, grant, out_valid, flit_count); end
    @(negedge clk); #1;
    checks++; if ({complete, grant, flit_count} !== {1'b0, 4'b0000, 5'd2})
      begin errors++; $display("FAIL single_after got=%b/%b/%0d exp=0/0000/2", complete, grant, flit_count); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    do_reset();
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int r = 0; r < 4; r++) set_flit(r, 13'(13'h1000 + r * 17));
    for (int k = 0; k < 5; k++) begin
      eg = 4'b0001 << (k % 4);
      #1;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rr_idle k=%0d got=%b exp=0000", k, grant); end
      @(negedge clk); #1;
      checks++; if (grant !== eg) begin errors++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, grant, eg); end
      checks++; if (out_packet !== 13'(13'h1000 + (k % 4) * 17)) begin errors++; $display("FAIL rr_data k=%0d got=%h", k, out_packet); end
      @(negedge clk); #1;
      checks++; if (complete !== 1'b1) begin errors++; $display("FAIL rr_complete k=%0d got=%b exp=1", k, complete); end
      @(negedge clk);
    end
    in_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 4'b0010; set_flit(1, 13'h0AB5); out_ready = 1'b1;
    #1; @(negedge clk); #1;
    checks++; if ({grant, out_packet} !== {4'b0010, 13'h0AB5}) begin errors++; $display("FAIL bp_first got=%b/%h exp=0010/0ab5", grant, out_packet); end
    @(negedge clk);
    set_flit(1, 13'h0C3E); out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if ({out_packet, in_ready, complete, out_valid, flit_count} !== {13'h0C3E, 4'b0000, 1'b0, 1'b1, 5'd1})
        begin errors++; $display("FAIL bp_stall i=%0d got=%h/%b/%b/%b/%0d exp=0c3e/0000/0/1/1", i, out_packet, in_ready, complete, out_valid, flit_count); end
      @(negedge clk);
    end
    out_ready = 1'b1; #1;
    checks++; if ({in_ready, flit_count} !== {4'b0010, 5'd1}) begin errors++; $display("FAIL bp_resume got=%b/%0d exp=0010/1", in_ready, flit_count); end
    @(negedge clk);
    set_flit(1, 13'h1FF2); #1; @(negedge clk);
    in_valid = 4'b0000; #1;
    checks++; if ({complete, flit_count} !== {1'b1, 5'd3}) begin errors++; $display("FAIL bp_done got=%b/%0d exp=1/3", complete, flit_count); end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    do_reset();
    in_valid = 4'b0100; out_ready = 1'b1; set_flit(2, 13'd2);
    #1; @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      set_flit(2, 13'(i * 16 + 2)); #1;
      checks++; if ({out_valid, out_packet, complete} !== {1'b1, 13'(i * 16 + 2), 1'b0})
        begin errors++; $display("FAIL ovf_flit i=%0d got=%b/%h/%b", i, out_valid, out_packet, complete); end
      @(negedge clk);
    end
    #1;
    checks++; if ({overflow, complete, flit_count, grant} !== {1'b1, 1'b1, 5'd16, 4'b0100})
      begin errors++; $display("FAIL ovf_done got=%b%b/%0d/%b exp=11/16/0100", overflow, complete, flit_count, grant); end
    @(negedge clk);
    in_valid = 4'b1111;
    for (int r = 0; r < 4; r++) set_flit(r, 13'(13'h1000 + r));
    #1;
    checks++; if ({overflow, grant} !== {1'b0, 4'b0000}) begin errors++; $display("FAIL ovf_idle got=%b/%b exp=0/0000", overflow, grant); end
    @(negedge clk); #1;
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL ovf_rr_next got=%b exp=1000", grant); end
    @(negedge clk);
    in_valid = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_valid_gap();
    do_reset();
    in_valid = 4'b0001; set_flit(0, 13'h0A51); set_flit(1, 13'h1B22); out_ready = 1'b1;
    #1; @(negedge clk); #1;
    checks++; if ({grant, out_packet} !== {4'b0001, 13'h0A51}) begin errors++; $display("FAIL gap_first got=%b/%h exp=0001/0a51", grant, out_packet); end
    @(negedge clk);
    in_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({grant, out_valid, in_ready, complete} !== {4'b0001, 1'b0, 4'b0001, 1'b0})
        begin errors++; $display("FAIL gap_hold i=%0d got=%b/%b/%b/%b exp=0001/0/0001/0", i, grant, out_valid, in_ready, complete); end
      @(negedge clk);
    end
    in_valid = 4'b0011; set_flit(0, 13'h1C34); #1;
    checks++; if ({out_valid, out_packet} !== {1'b1, 13'h1C34}) begin errors++; $display("FAIL gap_resume got=%b/%h exp=1/1c34", out_valid, out_packet); end
    @(negedge clk);
    in_valid = 4'b0010; #1;
    checks++; if ({complete, flit_count} !== {1'b1, 5'd2}) begin errors++; $display("FAIL gap_done got=%b/%0d exp=1/2", complete, flit_count); end
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL gap_next got=%b exp=0010", grant); end
    @(negedge clk);
    in_valid = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    in_valid = 4'b0100; set_flit(2, 13'h0777); out_ready = 1'b1;
    #1; @(negedge clk); #1;
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL rmid_grant got=%b exp=0100", grant); end
    @(negedge clk);
    #2; rst = 1'b1; #1;
    checks++; if ({grant, out_valid, in_ready, out_packet, flit_count, complete, overflow} !== 29'd0)
      begin errors++; $display("FAIL rmid_async got=%b/%b/%b/%h/%0d/%b%b exp=all zero", grant, out_valid, in_ready, out_packet, flit_count, complete, overflow); end
    @(negedge clk);
    rst = 1'b0; in_valid = 4'b1111;
    for (int r = 0; r < 4; r++) set_flit(r, 13'(13'h1000 + r));
    #1;
    checks++; if ({complete, grant} !== 5'd0) begin errors++; $display("FAIL rmid_release got=%b/%b exp=0/0000", complete, grant); end
    @(negedge clk); #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rmid_rearb got=%b exp=0001", grant); end
    @(negedge clk);
    in_valid = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_random();
    int owner, rr, cnt, ndone;
    bit ending, exp_ovf;
    logic [12:0] cur [4];
    logic [3:0] eg, er;
    do_reset();
    owner = -1; rr = 0; cnt = 0; ending = 1'b0; exp_ovf = 1'b0; ndone = 0;
    for (int r = 0; r < 4; r++) begin
      fq[r].delete();
      for (int p = 0; p < 8; p++) begin
        int len;
        len = (p < 7 && ($urandom % 5) == 0) ? 18 : 1 + int'($urandom % 4);
        for (int i = 0; i < len; i++) begin
          logic [12:0] f;
          f[12]    = (i == len - 1) && (len != 18);
          f[11:10] = 2'(r);
          f[9:0]   = 10'($urandom);
          fq[r].push_back(f);
        end
      end
    end
    for (int c = 0; c < 900; c++) begin
      out_ready = ($urandom % 4) != 0;
      for (int r = 0; r < 4; r++) begin
        cur[r] = (fq[r].size() > 0) ? fq[r][0] : 13'd0;
        in_valid[r] = (fq[r].size() > 0) && (($urandom % 3) != 0);
        set_flit(r, cur[r]);
      end
      #1;
      eg = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
      checks++; if (grant !== eg) begin errors++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, grant, eg); end
      if (ending) begin
        checks++;
        if ({complete, overflow, out_valid, in_ready, flit_count} !== {1'b1, exp_ovf, 1'b0, 4'b0000, 5'(cnt)})
          begin errors++; $display("FAIL rnd_done c=%0d got=%b%b/%b/%b/%0d exp=1%b/0/0000/%0d", c, complete, overflow, out_valid, in_ready, flit_count, exp_ovf, cnt); end
      end else if (owner >= 0) begin
        er = out_ready ? eg : 4'b0000;
        checks++;
        if ({complete, out_valid, out_packet, in_ready} !== {1'b0, in_valid[owner], cur[owner], er})
          begin errors++; $display("FAIL rnd_xfer c=%0d got=%b/%b/%h/%b exp=0/%b/%h/%b", c, complete, out_valid, out_packet, in_ready, in_valid[owner], cur[owner], er); end
      end else begin
        checks++;
        if ({complete, out_valid, in_ready, out_packet} !== 19'd0)
          begin errors++; $display("FAIL rnd_idle c=%0d got=%b/%b/%b/%h exp=0", c, complete, out_valid, in_ready, out_packet); end
      end
      if (ending) begin
        rr = (owner + 1) % 4; owner = -1; ending = 1'b0; exp_ovf = 1'b0; ndone++;
      end else if (owner >= 0) begin
        if (in_valid[owner] && out_ready) begin
          void'(fq[owner].pop_front());
          cnt = (cnt < 31) ? cnt + 1 : 31;
          if (cur[owner][12]) begin
            ending = 1'b1; exp_ovf = 1'b0;
          end else if (cnt == 16) begin
            ending = 1'b1; exp_ovf = 1'b1;
          end
        end
      end else if (in_valid != 4'b0000) begin
        owner = rr_pick(in_valid, rr); cnt = 0;
      end
      @(negedge clk);
    end
    checks++; if (ndone < 20) begin errors++; $display("FAIL rnd_progress got=%0d packets exp>=20", ndone); end
    in_valid = 4'b0000; out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 4'b0000; in_packet = 52'd0; out_ready = 1'b0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_valid_gap();
    test_reset_mid_packet();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
